// File: rtl/inst_fetch_pkg.sv
// ============================================================================
//  Module      : inst_fetch_pkg
//  Description : Shared widths, fetch FSM state type, queue entry type and
//                PC helper for the instruction fetch unit. Optional feature
//                macro used by the fetch unit: IF_ALIGN_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 32
`endif
`ifndef INST_NUM_LOG2
`define INST_NUM_LOG2 10
`endif
`ifndef PC_STEP
`define PC_STEP 4
`endif

package inst_fetch_pkg;

    localparam int ADDR_W  = `INST_ADDR_WIDTH;
    localparam int DATA_W  = `INST_DATA_WIDTH;
    localparam int PC_STEP = `PC_STEP;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2,
        S_ERR   = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_fifo.sv
// ============================================================================
//  Module      : inst_fifo
//  Description : Synchronous FIFO of {pc, inst} entries. Clear wins over push
//                and pop; a push into a full queue is accepted only when a pop
//                frees a slot in the same cycle. Head reads as zero when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  fetch_entry_t               push_data,
    output fetch_entry_t               head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Entry storage; writes are suppressed while the queue is being cleared.
    always_ff @(posedge clk) begin
        if (rst && !clear && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
//  Module      : inst_fetch
//  Description : Instruction fetch initiator. Owns the PC, drives the ROM
//                chip-enable/address, queues returned words with their PC and
//                hands them to decode over valid/ready. Branch redirects flush
//                the queue. Optional macro IF_ALIGN_CHECK_EN adds an
//                alignment error output and error state for bad redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               ce,
    output logic [ADDR_W-1:0]  addr,
    input  logic [DATA_W-1:0]  inst,
    input  logic               branch_flag,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [DATA_W-1:0]  id_inst,
    output logic [ADDR_W-1:0]  id_pc
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic               if_addr_err
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e       state;
    fetch_state_e       state_nxt;
    logic [ADDR_W-1:0]  pc;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_after;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               issue;
    logic               redirect;
    logic               misaligned;
    fetch_entry_t       push_entry;
    fetch_entry_t       head_entry;

    assign id_valid   = !fifo_empty;
    assign pop        = id_valid && id_ready;
    assign redirect   = branch_flag && (state != S_RESET);
    assign misaligned = (branch_target[1:0] != 2'b00);
    assign ce         = issue;
    assign addr       = pc;
    assign push_entry = '{pc: pc, inst: inst};
    assign id_inst    = head_entry.inst;
    assign id_pc      = head_entry.pc;
    assign count_after = count + CNT_W'(issue) - CNT_W'(pop);

    inst_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue),
        .pop       (pop),
        .clear     (redirect),
        .push_data (push_entry),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    // Fetch state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue decision and next-state logic; a pop frees a slot for a refill.
    always_comb begin
        issue     = 1'b0;
        state_nxt = state;
        case (state)
            S_RESET: begin
                state_nxt = S_FETCH;
            end
            S_FETCH, S_FULL: begin
                issue = !branch_flag && (!fifo_full || pop);
                if (branch_flag) begin
`ifdef IF_ALIGN_CHECK_EN
                    state_nxt = misaligned ? S_ERR : S_FETCH;
`else
                    state_nxt = S_FETCH;
`endif
                end else if (count_after == CNT_W'(FIFO_DEPTH)) begin
                    state_nxt = S_FULL;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_ERR: begin
`ifdef IF_ALIGN_CHECK_EN
                if (branch_flag && !misaligned) begin
                    state_nxt = S_FETCH;
                end
`else
                state_nxt = S_FETCH;
`endif
            end
            default: begin
                state_nxt = S_RESET;
            end
        endcase
    end

    // Program counter: redirect beats sequential advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
`ifdef IF_ALIGN_CHECK_EN
            pc <= branch_target;
`else
            pc <= align_pc(branch_target);
`endif
        end else if (issue) begin
            pc <= pc + ADDR_W'(PC_STEP);
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    // Sticky alignment error, updated by every redirect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if_addr_err <= 1'b0;
        end else if (redirect) begin
            if_addr_err <= misaligned;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = misaligned;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
//  Module      : tb_inst_fetch
//  Description : Self-checking bench for inst_fetch with a queue-based
//                reference model of the fetch/decode stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
`ifdef IF_ALIGN_CHECK_EN
    logic        if_addr_err;
`endif

    always #5 clk = ~clk;

    // ROM contents: a scrambled function of the byte address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    assign inst = rom_word(addr);

    inst_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce),
        .addr          (addr),
        .inst          (inst),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_inst       (id_inst),
        .id_pc         (id_pc)
`ifdef IF_ALIGN_CHECK_EN
        ,
        .if_addr_err   (if_addr_err)
`endif
    );

    int total  = 0;
    int passed = 0;

    // Reference model: PC, started flag, error flag and a queue of entries.
    bit          m_known   = 1'b0;
    bit          m_started = 1'b0;
    bit          m_err     = 1'b0;
    logic [31:0] m_pc      = 32'h0;
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // One clock: drive inputs, compare outputs against the model, advance the model.
    task automatic step(input logic r, input logic br, input logic [31:0] tgt, input logic rdy);
        logic exp_ce;
        logic exp_valid;
        exp_ce = 1'b0;
        @(negedge clk);
        rst = r;
        branch_flag = br;
        branch_target = tgt;
        id_ready = rdy;
        #1;
        exp_valid = (q_pc.size() > 0);
        if (m_known) begin
            exp_ce = m_started && !m_err && !br &&
                     ((q_pc.size() < DEPTH) || (exp_valid && rdy));
            chk("ce", {31'h0, ce}, {31'h0, exp_ce});
            chk("addr", addr, m_pc);
            chk("id_valid", {31'h0, id_valid}, {31'h0, exp_valid});
            if (exp_valid) begin
                chk("id_pc", id_pc, q_pc[0]);
                chk("id_inst", id_inst, q_inst[0]);
            end
            if (!m_started) begin
                chk("id_pc_rst", id_pc, 32'h0);
                chk("id_inst_rst", id_inst, 32'h0);
            end
`ifdef IF_ALIGN_CHECK_EN
            chk("if_addr_err", {31'h0, if_addr_err}, {31'h0, m_err});
`endif
        end
        @(posedge clk);
        if (!r) begin
            m_known   = 1'b1;
            m_started = 1'b0;
            m_err     = 1'b0;
            m_pc      = RESET_PC;
            q_pc.delete();
            q_inst.delete();
        end else if (m_known) begin
            if (!m_started) begin
                m_started = 1'b1;
            end else if (br) begin
                q_pc.delete();
                q_inst.delete();
`ifdef IF_ALIGN_CHECK_EN
                m_err = (tgt[1:0] != 2'b00);
                m_pc  = tgt;
`else
                m_pc  = tgt & 32'hFFFF_FFFC;
`endif
            end else begin
                if (exp_valid && rdy) begin
                    void'(q_pc.pop_front());
                    void'(q_inst.pop_front());
                end
                if (exp_ce) begin
                    q_pc.push_back(m_pc);
                    q_inst.push_back(rom_word(m_pc));
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] t;
        // Reset, then free-running fetch with decode always ready.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

        // Decode stalled from reset: queue fills, then drains with refill.
        step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

        // Queue holding 0x10/0x14, redirect to 0x40 during a pop.
        step(1'b1, 1'b1, 32'h10, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h40, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

        // PC wrap at the top of the address space.
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

        // Reset while full with a branch pending.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h200, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

        // Misaligned redirect, then an aligned one.
        step(1'b1, 1'b1, 32'h42, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h43, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h80, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            t = $urandom;
            if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
            step(($urandom_range(0, 59) != 0),
                 ($urandom_range(0, 9) == 0),
                 t,
                 ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
